// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one UART transmit buffer
// between two byte streams, with an idle-owner watchdog that forces a stalled grant free.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data_out,
  output logic       write_tx_data,
  input  logic       tx_buffer_full,
  output logic [1:0] grant,
  output logic       timeout_flag,
  input  logic       timeout_clear
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT - 1);

  state_t      state_r;
  logic [1:0]  grant_r;
  logic        last_owner_r;
  logic        wr_d_r;
  logic        timeout_flag_r;
  logic [15:0] idle_cnt_r;

  logic        owner_valid_s;
  logic        owner_last_s;
  logic [7:0]  owner_data_s;
  logic        accept_s;
  logic        expire_s;

  // Owner-side handshake, write strobe to the UART and watchdog expiry detect.
  always_comb begin
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    owner_valid_s = 1'b0;
    owner_last_s  = 1'b0;
    owner_data_s  = 8'h00;
    case (state_r)
      OWN0: begin
        req0_ready    = ~tx_buffer_full & ~wr_d_r;
        owner_valid_s = req0_valid;
        owner_last_s  = req0_last;
        owner_data_s  = req0_data;
      end
      OWN1: begin
        req1_ready    = ~tx_buffer_full & ~wr_d_r;
        owner_valid_s = req1_valid;
        owner_last_s  = req1_last;
        owner_data_s  = req1_data;
      end
      default: begin
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        owner_valid_s = 1'b0;
        owner_last_s  = 1'b0;
        owner_data_s  = 8'h00;
      end
    endcase
    accept_s      = owner_valid_s & (req0_ready | req1_ready);
    write_tx_data = accept_s;
    if (accept_s) begin
      tx_data_out = owner_data_s;
    end else begin
      tx_data_out = 8'h00;
    end
    // A stall only counts toward expiry while the owner has nothing to offer.
    expire_s = (state_r != IDLE) & ~owner_valid_s & (idle_cnt_r == IDLE_MAX);
  end

  // Arbitration FSM with registered grant, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      grant_r        <= 2'b00;
      last_owner_r   <= 1'b1;
      wr_d_r         <= 1'b0;
      timeout_flag_r <= 1'b0;
      idle_cnt_r     <= 16'd0;
    end else begin
      wr_d_r <= accept_s;
      if (expire_s) begin
        timeout_flag_r <= 1'b1;
      end else if (timeout_clear) begin
        timeout_flag_r <= 1'b0;
      end else begin
        timeout_flag_r <= timeout_flag_r;
      end
      case (state_r)
        IDLE: begin
          idle_cnt_r <= 16'd0;
          // On a tie the requester that did not own the buffer last time wins.
          if (req0_valid && (!req1_valid || last_owner_r)) begin
            state_r      <= OWN0;
            grant_r      <= 2'b01;
            last_owner_r <= 1'b0;
          end else if (req1_valid) begin
            state_r      <= OWN1;
            grant_r      <= 2'b10;
            last_owner_r <= 1'b1;
          end else begin
            state_r <= IDLE;
            grant_r <= 2'b00;
          end
        end
        OWN0, OWN1: begin
          if ((accept_s && owner_last_s) || expire_s) begin
            state_r    <= IDLE;
            grant_r    <= 2'b00;
            idle_cnt_r <= 16'd0;
          end else if (accept_s) begin
            idle_cnt_r <= 16'd0;
          end else if (!owner_valid_s && (idle_cnt_r != IDLE_MAX)) begin
            idle_cnt_r <= idle_cnt_r + 16'd1;
          end else begin
            idle_cnt_r <= idle_cnt_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          grant_r    <= 2'b00;
          idle_cnt_r <= 16'd0;
        end
      endcase
    end
  end

  assign grant        = grant_r;
  assign timeout_flag = timeout_flag_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table for one packet, then queue-driven requesters
// with a byte scoreboard for arbitration, isolation, backpressure, watchdog and reset.
module tb_uart_tx_arbiter;
  localparam int unsigned TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] tx_data_out;
  logic       write_tx_data, tx_buffer_full;
  logic [1:0] grant;
  logic       timeout_flag, timeout_clear;

  uart_tx_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data_out(tx_data_out), .write_tx_data(write_tx_data), .tx_buffer_full(tx_buffer_full),
    .grant(grant), .timeout_flag(timeout_flag), .timeout_clear(timeout_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic [1:0] e_grant;
    logic       e_wr;
    logic [7:0] e_data;
    logic       e_rdy0;
  } vec_t;

  int checks = 0;
  int fails  = 0;

  beat_t      q0[$];
  beat_t      q1[$];
  logic [7:0] exp_q[$];
  logic [1:0] ghist[$];
  logic [1:0] prev_grant;

  logic       use_model = 1'b1;
  logic       en0 = 1'b0, en1 = 1'b0, noise1 = 1'b0;
  logic       full_v = 1'b0, clr_v = 1'b0;
  logic       t_v0 = 1'b0, t_l0 = 1'b0;
  logic [7:0] t_d0 = 8'h00;
  logic       saw_wr;
  logic [7:0] saw_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int who, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    if (who == 0) q0.push_back(b);
    else q1.push_back(b);
    exp_q.push_back(d);
  endtask

  // One clock: drive at the falling edge, sample 1 ns later (before the next rising edge).
  task automatic step();
    @(negedge clk);
    if (use_model) begin
      if (en0 && q0.size() > 0) begin
        req0_valid = 1'b1; req0_data = q0[0].data; req0_last = q0[0].last;
      end else begin
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
      end
      if (en1 && q1.size() > 0) begin
        req1_valid = 1'b1; req1_data = q1[0].data; req1_last = q1[0].last;
      end else begin
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
      end
      if (noise1 && q0.size() > 1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_data  = 8'($urandom_range(0, 255));
        req1_last  = 1'($urandom_range(0, 1));
      end
    end else begin
      req0_valid = t_v0; req0_data = t_d0; req0_last = t_l0;
      req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    end
    tx_buffer_full = full_v;
    timeout_clear  = clr_v;
    #1;
    saw_wr   = write_tx_data;
    saw_data = tx_data_out;
    if (grant !== prev_grant) begin
      ghist.push_back(grant);
      prev_grant = grant;
    end
    if (use_model) begin
      if (write_tx_data) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_write: got byte %0h, expected no write", tx_data_out);
        end else begin
          check("tx_data", 32'(tx_data_out), 32'(exp_q.pop_front()));
        end
      end else begin
        check("idle_data_zero", 32'(tx_data_out), 32'h0);
      end
      if (grant !== 2'b01) check("nonowner_ready0", 32'(req0_ready), 32'h0);
      if (grant !== 2'b10) check("nonowner_ready1", 32'(req1_ready), 32'h0);
      if (req0_valid && req0_ready && q0.size() > 0) void'(q0.pop_front());
      if (req1_valid && req1_ready && q1.size() > 0 && !(noise1 && q0.size() > 0)) void'(q1.pop_front());
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || grant !== 2'b00) && n < limit) begin
      step();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic wait_write(input string name, input int limit);
    int n = 0;
    saw_wr = 1'b0;
    while (!saw_wr && n < limit) begin
      step();
      n++;
    end
    check({name, "_write_seen"}, 32'(saw_wr), 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0; noise1 = 1'b0; full_v = 1'b0; clr_v = 1'b0;
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_ghist(input string name);
    logic [1:0] want[4];
    want[0] = 2'b01; want[1] = 2'b00; want[2] = 2'b10; want[3] = 2'b00;
    check({name, "_grant_changes"}, 32'(ghist.size()), 32'd4);
    for (int i = 0; i < 4 && i < ghist.size(); i++) check({name, "_grant_seq"}, 32'(ghist[i]), 32'(want[i]));
  endtask

  initial begin
    vec_t tbl[8];
    tbl[0] = '{1'b1, 8'h41, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'h41, 1'b0, 2'b01, 1'b1, 8'h41, 1'b1};
    tbl[2] = '{1'b1, 8'h42, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{1'b1, 8'h42, 1'b0, 2'b01, 1'b1, 8'h42, 1'b1};
    tbl[4] = '{1'b1, 8'h43, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 8'h43, 1'b1, 2'b01, 1'b1, 8'h43, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};

    reset = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    tx_buffer_full = 1'b0; timeout_clear = 1'b0;
    prev_grant = 2'b00;
    step();
    step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_write", 32'(write_tx_data), 32'h0);
    check("rst_data", 32'(tx_data_out), 32'h0);
    check("rst_ready0", 32'(req0_ready), 32'h0);
    check("rst_ready1", 32'(req1_ready), 32'h0);
    check("rst_flag", 32'(timeout_flag), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single packet, cycle by cycle; byte 43 carries last while blocked, then when accepted.
    use_model = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t_v0 = tbl[i].v0; t_d0 = tbl[i].d0; t_l0 = tbl[i].l0;
      step();
      check($sformatf("pkt_grant[%0d]", i), 32'(grant), 32'(tbl[i].e_grant));
      check($sformatf("pkt_write[%0d]", i), 32'(write_tx_data), 32'(tbl[i].e_wr));
      check($sformatf("pkt_data[%0d]", i), 32'(tx_data_out), 32'(tbl[i].e_data));
      check($sformatf("pkt_ready0[%0d]", i), 32'(req0_ready), 32'(tbl[i].e_rdy0));
      check($sformatf("pkt_ready1[%0d]", i), 32'(req1_ready), 32'h0);
    end
    use_model = 1'b1;

    // Tie from reset: requester 0 first, whole packets, no interleave.
    do_reset();
    ghist.delete();
    prev_grant = grant;
    load(0, 8'h11, 1'b0); load(0, 8'h12, 1'b1);
    load(1, 8'h21, 1'b0); load(1, 8'h22, 1'b1);
    en0 = 1'b1; en1 = 1'b1;
    drain("tie", 60);
    check_ghist("tie");

    // Requester 1 chatters while requester 0 owns the buffer.
    for (int i = 0; i < 6; i++) load(0, 8'(8'h91 + i), 1'(i == 5));
    noise1 = 1'b1;
    drain("isolation", 80);
    noise1 = 1'b0;

    // Backpressure: ten full cycles mid-packet.
    load(0, 8'h31, 1'b0); load(0, 8'h32, 1'b0); load(0, 8'h33, 1'b1);
    wait_write("bp_first", 10);
    full_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_write", 32'(write_tx_data), 32'h0);
      check("bp_ready0", 32'(req0_ready), 32'h0);
      check("bp_grant", 32'(grant), 32'h1);
      check("bp_flag", 32'(timeout_flag), 32'h0);
    end
    full_v = 1'b0;
    step();
    check("bp_resume_write", 32'(write_tx_data), 32'h1);
    check("bp_resume_data", 32'(tx_data_out), 32'h32);
    drain("bp", 40);

    // Watchdog: one byte without last, then silence.
    load(1, 8'h51, 1'b0);
    wait_write("wd_accept", 10);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("wd_hold_grant[%0d]", i), 32'(grant), 32'h2);
      check($sformatf("wd_hold_flag[%0d]", i), 32'(timeout_flag), 32'h0);
    end
    step();
    check("wd_release_grant", 32'(grant), 32'h0);
    check("wd_flag_set", 32'(timeout_flag), 32'h1);
    clr_v = 1'b1;
    step();
    check("wd_flag_sticky", 32'(timeout_flag), 32'h1);
    clr_v = 1'b0;
    step();
    check("wd_flag_cleared", 32'(timeout_flag), 32'h0);

    // Reset in the middle of a requester 1 packet.
    load(1, 8'h61, 1'b0); load(1, 8'h62, 1'b0); load(1, 8'h63, 1'b1);
    wait_write("mid_first", 10);
    check("mid_grant_before", 32'(grant), 32'h2);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_write", 32'(write_tx_data), 32'h0);
    check("mid_rst_data", 32'(tx_data_out), 32'h0);
    check("mid_rst_ready1", 32'(req1_ready), 32'h0);
    check("mid_rst_flag", 32'(timeout_flag), 32'h0);
    q0.delete(); q1.delete(); exp_q.delete();
    en0 = 1'b0; en1 = 1'b0;
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    ghist.delete();
    prev_grant = grant;
    load(0, 8'h71, 1'b1);
    load(1, 8'h81, 1'b1);
    en0 = 1'b1; en1 = 1'b1;
    drain("post_rst_tie", 40);
    check_ghist("post_rst_tie");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
